reg_rename_unit: RTL

//  Parametrised rename stage between ID/RN buffer and dispatch. Maps arch rd/rs1/rs2 to phys regs via

---
 rtl/rename_pkg.sv | 18 +
 rtl/rename_free_list.sv | 101 ++++++++++
 rtl/reg_rename_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rename_pkg.sv
// Shared widths, register typedefs and free-list sizing for the rename stage.
package rename_pkg;

    localparam int ARCH_REGS_DEF = 32;
    localparam int PHYS_REGS_DEF = 64;
    localparam int AW            = $clog2(ARCH_REGS_DEF);
    localparam int PW            = $clog2(PHYS_REGS_DEF);
    localparam int FL_DEPTH      = PHYS_REGS_DEF - ARCH_REGS_DEF;

    typedef logic [AW-1:0] arch_reg_t;
    typedef logic [PW-1:0] phys_reg_t;

    // Ring pointer width; a depth of one still needs a one-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical registers: pop at head, push at tail.
// With RENAME_FLUSH_EN, also tracks commit_head and rewinds head to it on flush.
module rename_free_list
    import rename_pkg::*;
#(
    parameter int ARCH_REGS = ARCH_REGS_DEF,
    parameter int PHYS_REGS = PHYS_REGS_DEF,
    localparam int PBITS = $clog2(PHYS_REGS),
    localparam int CBITS = PBITS + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pop,
    output logic [PBITS-1:0] pop_data,
    input  logic             push,
    input  logic [PBITS-1:0] push_data,
`ifdef RENAME_FLUSH_EN
    input  logic             flush,
    input  logic             commit,
`endif
    output logic [CBITS-1:0] count
);

    localparam int DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int PTRW  = ptr_width(DEPTH);
    localparam logic [PTRW-1:0]  LAST = PTRW'(DEPTH - 1);
    localparam logic [CBITS-1:0] FULL = CBITS'(DEPTH);

    logic [PBITS-1:0] mem_q [DEPTH];
    logic [PBITS-1:0] mem_d [DEPTH];
    logic [PTRW-1:0]  head_q, head_d;
    logic [PTRW-1:0]  tail_q, tail_d;
    logic [CBITS-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Explicit wrap so a non-power-of-two ring depth still works.
    function automatic logic [PTRW-1:0] wrap_inc(input logic [PTRW-1:0] p);
        return (p == LAST) ? '0 : p + PTRW'(1);
    endfunction

`ifdef RENAME_FLUSH_EN
    logic [PTRW-1:0] commit_q, commit_d;
`endif

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        push_ok = push && (count_q != FULL);
        pop_ok  = pop && (count_q != '0);
        if (push_ok) begin
            mem_d[tail_q] = push_data;
            tail_d        = wrap_inc(tail_q);
        end
        if (pop_ok) begin
            head_d = wrap_inc(head_q);
        end
        count_d = count_q + CBITS'(push_ok) - CBITS'(pop_ok);
`ifdef RENAME_FLUSH_EN
        commit_d = commit_q;
        if (commit) begin
            commit_d = wrap_inc(commit_q);
        end
        // Everything past the committed head becomes free again.
        if (flush) begin
            head_d  = commit_d;
            count_d = FULL;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PBITS'(ARCH_REGS + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= FULL;
`ifdef RENAME_FLUSH_EN
            commit_q <= '0;
`endif
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
`ifdef RENAME_FLUSH_EN
            commit_q <= commit_d;
`endif
        end
    end

    assign pop_data = mem_q[head_q];
    assign count    = count_q;

    push_when_full: assert property (@(posedge clk) disable iff (reset)
        !(push && (count_q == FULL)));

endmodule

// File: rtl/reg_rename_unit.sv
// Rename stage: speculative RAT plus free list, valid/ready on both sides.
// Optional mispredict recovery (committed RAT, flush input) under RENAME_FLUSH_EN.
module reg_rename_unit
    import rename_pkg::*;
#(
    parameter int ARCH_REGS = ARCH_REGS_DEF,
    parameter int PHYS_REGS = PHYS_REGS_DEF,
    localparam int AB = $clog2(ARCH_REGS),
    localparam int PB = $clog2(PHYS_REGS)
) (
    input  logic          clk,
    input  logic          reset,
`ifdef RENAME_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AB-1:0] in_rd,
    input  logic [AB-1:0] in_rs1,
    input  logic [AB-1:0] in_rs2,
    input  logic          in_reg_write,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PB-1:0] out_phys_rd,
    output logic [PB-1:0] out_phys_rs1,
    output logic [PB-1:0] out_phys_rs2,
    output logic [PB-1:0] out_old_phys_rd,
    output logic          out_reg_write,
    input  logic          retire_valid,
    input  logic          retire_reg_write,
    input  logic [AB-1:0] retire_arch_rd,
    input  logic [PB-1:0] retire_phys_rd,
    input  logic [PB-1:0] retire_old_phys_rd,
    output logic [PB:0]   free_count,
    output logic          free_list_empty
);

    // Handshake: a transfer happens on a cycle where valid and ready are both
    // high at the rising edge; out_* stay stable while out_valid && !out_ready.

    logic [PB-1:0] rat_q [ARCH_REGS];
    logic [PB-1:0] rat_d [ARCH_REGS];
    logic          out_valid_q, out_valid_d;
    logic [PB-1:0] out_phys_rd_q, out_phys_rd_d;
    logic [PB-1:0] out_phys_rs1_q, out_phys_rs1_d;
    logic [PB-1:0] out_phys_rs2_q, out_phys_rs2_d;
    logic [PB-1:0] out_old_phys_rd_q, out_old_phys_rd_d;
    logic          out_reg_write_q, out_reg_write_d;
    logic          accept;
    logic          alloc;
    logic          retire_push;
    logic [PB-1:0] fl_pop_data;
    logic [PB:0]   fl_count;

`ifdef RENAME_FLUSH_EN
    logic [PB-1:0] crat_q [ARCH_REGS];
    logic [PB-1:0] crat_d [ARCH_REGS];
    assign in_ready = (!out_valid_q || out_ready) && (fl_count != '0) && !flush;
`else
    logic unused_retire_phys;
    assign unused_retire_phys = ^retire_phys_rd;
    assign in_ready = (!out_valid_q || out_ready) && (fl_count != '0);
`endif

    assign accept      = in_valid && in_ready;
    assign alloc       = accept && in_reg_write && (in_rd != '0);
    assign retire_push = retire_valid && retire_reg_write && (retire_arch_rd != '0);

    rename_free_list #(
        .ARCH_REGS (ARCH_REGS),
        .PHYS_REGS (PHYS_REGS)
    ) u_free_list (
        .clk       (clk),
        .reset     (reset),
        .pop       (alloc),
        .pop_data  (fl_pop_data),
        .push      (retire_push),
        .push_data (retire_old_phys_rd),
`ifdef RENAME_FLUSH_EN
        .flush     (flush),
        .commit    (retire_push),
`endif
        .count     (fl_count)
    );

    always_comb begin
        rat_d             = rat_q;
        out_valid_d       = out_valid_q;
        out_phys_rd_d     = out_phys_rd_q;
        out_phys_rs1_d    = out_phys_rs1_q;
        out_phys_rs2_d    = out_phys_rs2_q;
        out_old_phys_rd_d = out_old_phys_rd_q;
        out_reg_write_d   = out_reg_write_q;
        if (alloc) begin
            rat_d[in_rd] = fl_pop_data;
        end
        // Sources read the RAT before this instruction's own rd update.
        if (accept) begin
            out_valid_d       = 1'b1;
            out_phys_rs1_d    = (in_rs1 == '0) ? '0 : rat_q[in_rs1];
            out_phys_rs2_d    = (in_rs2 == '0) ? '0 : rat_q[in_rs2];
            out_phys_rd_d     = alloc ? fl_pop_data : '0;
            out_old_phys_rd_d = alloc ? rat_q[in_rd] : '0;
            out_reg_write_d   = alloc;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
`ifdef RENAME_FLUSH_EN
        crat_d = crat_q;
        if (retire_push) begin
            crat_d[retire_arch_rd] = retire_phys_rd;
        end
        if (flush) begin
            rat_d       = crat_d;
            out_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat_q[i] <= PB'(i);
            end
            out_valid_q       <= 1'b0;
            out_phys_rd_q     <= '0;
            out_phys_rs1_q    <= '0;
            out_phys_rs2_q    <= '0;
            out_old_phys_rd_q <= '0;
            out_reg_write_q   <= 1'b0;
        end else begin
            rat_q             <= rat_d;
            out_valid_q       <= out_valid_d;
            out_phys_rd_q     <= out_phys_rd_d;
            out_phys_rs1_q    <= out_phys_rs1_d;
            out_phys_rs2_q    <= out_phys_rs2_d;
            out_old_phys_rd_q <= out_old_phys_rd_d;
            out_reg_write_q   <= out_reg_write_d;
        end
    end

`ifdef RENAME_FLUSH_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                crat_q[i] <= PB'(i);
            end
        end else begin
            crat_q <= crat_d;
        end
    end
`endif

    assign out_valid       = out_valid_q;
    assign out_phys_rd     = out_phys_rd_q;
    assign out_phys_rs1    = out_phys_rs1_q;
    assign out_phys_rs2    = out_phys_rs2_q;
    assign out_old_phys_rd = out_old_phys_rd_q;
    assign out_reg_write   = out_reg_write_q;
    assign free_count      = fl_count;
    assign free_list_empty = (fl_count == '0);

endmodule
